servo_pwm_multi: RTL and testbench
==================================

# servo_pwm_multi

Parametrised multi-channel servo pulse generator for the passcode lock and later actuator work. Generates NUM_CH independent 50 Hz-style servo pulse trains sharing one frame counter. Each channel's pulse width is written at run time through a single write port, clamped to a safe range, and applied only at frame boundaries, so output pulses never glitch. An optional slew limiter ramps each channel toward its target.

## Interface
Parameters:
- NUM_CH, 4, number of servo channels (1..16)
- PERIOD, 500000, frame length in clocks (20 ms @ 25 MHz)
- CNT_W, 20, counter/width bit width; must satisfy 2^CNT_W > PERIOD
- MIN_WIDTH, 17000, lowest legal pulse width in clocks (0.68 ms)
- MAX_WIDTH, 62000, highest legal pulse width in clocks (2.48 ms)
- RESET_WIDTH, 17000, width of every channel after reset (latch closed)
- STEP, 500, maximum width change per frame when slew is compiled in

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  reset, synchronous, active-high
- i_Wr_En  in  1  write strobe, one cycle per write
- i_Wr_Ch  in  4  target channel index
- i_Wr_Width  in  CNT_W  requested pulse width in clocks
- o_Wr_Err  out  1  one-cycle pulse: write rejected (bad channel)
- o_Servo  out  NUM_CH  servo pulse outputs, bit n = channel n
- o_Busy  out  NUM_CH  bit n high while channel n current width ≠ target
- o_Frame_Start  out  1  one-cycle pulse in first output cycle of each frame

## Operation
- Frame counter counts 0..PERIOD-1, wraps to 0. There is no idle state; it runs continuously out of reset.
- Per channel: target register (write side) and current register (drives output).
- Write: on i_Wr_En, if i_Wr_Ch < NUM_CH, then target[ch] <= clamp(i_Wr_Width, MIN_WIDTH, MAX_WIDTH). Otherwise no state changes and o_Wr_Err pulses on the next cycle.
- Frame update: in the cycle counter == PERIOD-1, every current[n] is loaded from the target[n] value held before that edge. A write in that same cycle updates target and takes effect one frame later.
- Output: o_Servo[n] is registered as (counter < current[n]). Pulse is high for exactly current[n] cycles per frame.
- o_Busy[n] = (current[n] != target[n]), registered.
- Reset (any time, including mid-pulse): counter=0, all target=current=RESET_WIDTH, o_Servo=0, o_Busy=0, o_Wr_Err=0, o_Frame_Start=0. Pulses are truncated immediately. The next frame starts on the first cycle after reset deasserts.
- Width arithmetic is unsigned CNT_W. The clamp compares against the full i_Wr_Width, with no truncation.

## Timing
- Output latency is 1 cycle from counter value. The counter==0 cycle produces the o_Servo rising edge and o_Frame_Start in the next cycle.
- First frame after reset: o_Servo high for RESET_WIDTH cycles, starting 1 cycle after i_Rst falls.
- Write-to-output latency: a write at counter value k appears in the frame beginning after the next wrap.
- o_Wr_Err latency is 1 cycle. Back-to-back writes are accepted every cycle. Multiple writes to one channel within a frame: the last write wins.

## Configuration
- SERVO_SLEW_EN defined: at the frame update, if |target-current| ≤ STEP, then current=target. Otherwise current moves STEP toward target. o_Busy stays high across the ramp.
- SERVO_SLEW_EN undefined: current=target at the frame update, so o_Busy is high for at most one frame. The STEP parameter is ignored.

## Test plan
- Reset release -> o_Servo[all] high 17000 cycles, low 483000, repeating. o_Frame_Start every 500000 cycles. o_Busy=0.
- Slew off, write ch0=62000 at counter 1000 -> ch0 pulse 62000 cycles starting next frame. Other channels unchanged at 17000.
- Writes of 70000 and 5000 to ch1 -> observed pulses 62000 and 17000 respectively. Write ch=4 (NUM_CH=4) -> o_Wr_Err one cycle, no output change.
- Slew on, STEP=500, write ch2=62000 -> width increases 500 per frame. Reaches 62000 after 90 frames. o_Busy[2] drops after the 90th update.
- Write ch3=40000 in the counter==PERIOD-1 cycle -> the next frame still shows the old width. The following frame shows 40000 (slew off).
- Assert i_Rst for 3 cycles at counter 30000 while ch0=62000 -> o_Servo drops at once. After release, 17000-cycle pulses resume and targets revert to 17000.

Source files
------------

// File: rtl/servo_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pwm_multi
//  Purpose  : NUM_CH servo pulse generators sharing one free-running frame
//             counter. Widths are written through a single clamped write
//             port and applied only at frame boundaries, so pulses never
//             glitch.
//  Option   : define SERVO_SLEW_EN to limit each channel's width change to
//             STEP clocks per frame (ramp toward the target).
//  Revision : 1.0  initial release
// ============================================================================
module servo_pwm_multi #(
  parameter int NUM_CH      = 4,
  parameter int PERIOD      = 500000,
  parameter int CNT_W       = 20,
  parameter int MIN_WIDTH   = 17000,
  parameter int MAX_WIDTH   = 62000,
  parameter int RESET_WIDTH = 17000,
  parameter int STEP        = 500
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Wr_En,
  input  logic [3:0]        i_Wr_Ch,
  input  logic [CNT_W-1:0]  i_Wr_Width,
  output logic              o_Wr_Err,
  output logic [NUM_CH-1:0] o_Servo,
  output logic [NUM_CH-1:0] o_Busy,
  output logic              o_Frame_Start
);

  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] C_MIN   = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] C_RST_W = CNT_W'(RESET_WIDTH);
  localparam logic [4:0]       C_NCH   = 5'(NUM_CH);

  // Without the slew option the step is "unbounded", so every frame update
  // jumps straight to the target and STEP has no effect.
  localparam logic [CNT_W-1:0] C_STEP =
`ifdef SERVO_SLEW_EN
    CNT_W'(STEP);
`else
    {CNT_W{1'b1}};
`endif

  logic [CNT_W-1:0] cnt_q;
  logic             frame_q;
  logic             err_q;
  logic             w_frame_end;
  logic             w_wr_ok;
  logic [CNT_W-1:0] w_clamped;

  assign w_frame_end = (cnt_q == C_LAST);
  assign w_wr_ok     = i_Wr_En && ({1'b0, i_Wr_Ch} < C_NCH);

  // Clamp the full requested width into the safe servo range.
  always_comb begin
    w_clamped = i_Wr_Width;
    if (i_Wr_Width < C_MIN) begin
      w_clamped = C_MIN;
    end else if (i_Wr_Width > C_MAX) begin
      w_clamped = C_MAX;
    end
  end

  // Free-running frame counter plus the frame-start and write-error pulses.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q   <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= w_frame_end ? '0 : cnt_q + 1'b1;
      frame_q <= (cnt_q == '0);
      err_q   <= i_Wr_En && !w_wr_ok;
    end
  end

  assign o_Frame_Start = frame_q;
  assign o_Wr_Err      = err_q;

  generate
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      logic [CNT_W-1:0] target_q;
      logic [CNT_W-1:0] current_q;
      logic [CNT_W-1:0] current_d;
      logic             servo_q;
      logic             busy_q;

      // Next frame's width: move toward the target by at most C_STEP.
      always_comb begin
        current_d = target_q;
        if (target_q > current_q) begin
          if ((target_q - current_q) > C_STEP) begin
            current_d = current_q + C_STEP;
          end
        end else if (target_q < current_q) begin
          if ((current_q - target_q) > C_STEP) begin
            current_d = current_q - C_STEP;
          end
        end
      end

      // Target/current width registers and the registered pulse and busy flags.
      always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
          target_q  <= C_RST_W;
          current_q <= C_RST_W;
          servo_q   <= 1'b0;
          busy_q    <= 1'b0;
        end else begin
          if (w_wr_ok && (i_Wr_Ch == 4'(n))) begin
            target_q <= w_clamped;
          end
          if (w_frame_end) begin
            current_q <= current_d;
          end
          servo_q <= (cnt_q < current_q);
          busy_q  <= (current_q != target_q);
        end
      end

      assign o_Servo[n] = servo_q;
      assign o_Busy[n]  = busy_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_servo_pwm_multi
//  Purpose  : Randomised self-checking bench for servo_pwm_multi against a
//             frame-level behavioural model (SERVO_SLEW_EN honoured).
//  Revision : 1.0  initial release
// ============================================================================
module tb_servo_pwm_multi;

  localparam int NUM_CH = 4;
  localparam int PERIOD = 100;
  localparam int CNT_W  = 8;
  localparam int MIN_W  = 20;
  localparam int MAX_W  = 80;
  localparam int RST_W  = 25;
  localparam int STEP   = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [3:0]        wr_ch;
  logic [CNT_W-1:0]  wr_width;
  logic              wr_err;
  logic [NUM_CH-1:0] servo;
  logic [NUM_CH-1:0] busy;
  logic              frame_start;

  servo_pwm_multi #(
    .NUM_CH(NUM_CH), .PERIOD(PERIOD), .CNT_W(CNT_W), .MIN_WIDTH(MIN_W),
    .MAX_WIDTH(MAX_W), .RESET_WIDTH(RST_W), .STEP(STEP)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Wr_En(wr_en), .i_Wr_Ch(wr_ch),
    .i_Wr_Width(wr_width), .o_Wr_Err(wr_err), .o_Servo(servo),
    .o_Busy(busy), .o_Frame_Start(frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: position in frame, per-channel target and width.
  int m_cnt;
  int m_tgt [NUM_CH];
  int m_cur [NUM_CH];
  logic [NUM_CH-1:0] e_servo, e_busy;
  logic e_fs, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int clampw(input int w);
    if (w < MIN_W) return MIN_W;
    if (w > MAX_W) return MAX_W;
    return w;
  endfunction

  function automatic int approach(input int cur, input int tgt);
`ifdef SERVO_SLEW_EN
    if (tgt - cur > STEP) return cur + STEP;
    if (cur - tgt > STEP) return cur - STEP;
`endif
    return tgt;
  endfunction

  // Apply one clock edge of the spec's rules to the model.
  task automatic model_edge();
    if (rst) begin
      m_cnt = 0;
      for (int n = 0; n < NUM_CH; n++) begin
        m_tgt[n] = RST_W;
        m_cur[n] = RST_W;
      end
      e_servo = '0; e_busy = '0; e_fs = 1'b0; e_err = 1'b0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        e_servo[n] = (m_cnt < m_cur[n]);
        e_busy[n]  = (m_cur[n] != m_tgt[n]);
      end
      e_fs  = (m_cnt == 0);
      e_err = wr_en && (int'(wr_ch) >= NUM_CH);
      if (m_cnt == PERIOD - 1)
        for (int n = 0; n < NUM_CH; n++) m_cur[n] = approach(m_cur[n], m_tgt[n]);
      if (wr_en && int'(wr_ch) < NUM_CH) m_tgt[wr_ch] = clampw(int'(wr_width));
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("servo",       32'(servo),       32'(e_servo));
    chk("busy",        32'(busy),        32'(e_busy));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("wr_err",      32'(wr_err),      32'(e_err));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic do_write(input int ch, input int w);
    wr_en = 1'b1; wr_ch = 4'(ch); wr_width = CNT_W'(w);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_cnt(input int k);
    for (int i = 0; i <= PERIOD && m_cnt != k; i++) tick();
    chk("wait_cnt", 32'(m_cnt), 32'(k));
  endtask

  // Count the high cycles of one channel over a whole frame.
  task automatic measure(input int ch, input int exp_w);
    int hi;
    hi = 0;
    wait_cnt(0);
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      if (servo[ch] === 1'b1) hi++;
    end
    chk($sformatf("width_ch%0d", ch), 32'(hi), 32'(exp_w));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_width = '0;
    m_cnt = 0;
    for (int n = 0; n < NUM_CH; n++) begin m_tgt[n] = RST_W; m_cur[n] = RST_W; end
    run(3);
    rst = 1'b0;
    measure(0, RST_W);
    run(PERIOD + 7);

    // Mid-frame write of the maximum width to channel 0.
    wait_cnt(10);
    do_write(0, MAX_W);
    run(2 * PERIOD);

    // Clamp boundaries and rejected channels.
    do_write(1, 200);
    run(2 * PERIOD);
    do_write(1, 5);
    run(2 * PERIOD);
    do_write(4, 50);
    do_write(15, 50);
    run(5);

    // Write landing exactly on the frame-update cycle.
    wait_cnt(PERIOD - 1);
    do_write(3, 60);
    run(2 * PERIOD);

    // Back-to-back writes, last one wins.
    wr_en = 1'b1;
    wr_ch = 4'd2; wr_width = 8'd30; tick();
    wr_width = 8'd40; tick();
    wr_width = 8'd70; tick();
    wr_en = 1'b0;
    run(PERIOD);

    // Random write traffic, including illegal channels and out-of-range widths.
    for (int i = 0; i < 8 * PERIOD; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        wr_en = 1'b1;
        wr_ch = 4'($urandom_range(0, 5));
        wr_width = CNT_W'($urandom_range(0, 255));
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    run(PERIOD);

    // Reset in the middle of a long pulse.
    do_write(0, MAX_W);
    run(2 * PERIOD);
    wait_cnt(30);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2 * PERIOD);

    // Large step on channel 2 (ramps when slew is compiled in).
    do_write(2, MAX_W);
    run(12 * PERIOD);
    measure(2, MAX_W);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
